// File: rtl/fnd_regs_pkg.sv
// Shared definitions for the FND AXI4-Lite register block.
// Register offsets, CTRL bit positions, value limit and FSM state types.
// Also holds the byte-strobe merge helper used on the write path.
package fnd_regs_pkg;

  // Byte offsets of the word-aligned registers
  localparam logic [3:0] OFF_CTRL     = 4'h0;
  localparam logic [3:0] OFF_VALUE    = 4'h4;
  localparam logic [3:0] OFF_VERSION  = 4'h8;
  localparam logic [3:0] OFF_TICK_DIV = 4'hC;

  // CTRL bit indices
  localparam int CTRL_ON    = 0;
  localparam int CTRL_CLEAR = 1;
  localparam int CTRL_AUTO  = 2;

  // Largest value the 4-digit display can show
  localparam int unsigned VALUE_MAX = 9999;
  localparam int          VALUE_W   = 14;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_A,
    W_HAVE_D,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_e;

  // Replace the bytes of old_w selected by be with the matching bytes of new_w
  function automatic logic [31:0] apply_strb(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/fnd_axi_lite_regs_if.sv
// AXI4-Lite bus bundle (32-bit data) between the interconnect and the FND register block.
// No storage; pure wiring.
// Master drives valids and payloads, slave drives readys and responses.
interface fnd_axi_lite_regs_if #(
  parameter int C_ADDR_WIDTH = 4
);
  logic [C_ADDR_WIDTH-1:0] awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [31:0]             wdata;
  logic [3:0]              wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [C_ADDR_WIDTH-1:0] araddr;
  logic                    arvalid;
  logic                    arready;
  logic [31:0]             rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/fnd_tick_prescaler.sv
// Prescaler: counts 0..i_div-1 while enabled and flags the terminal count (i_div of 0 acts as 1).
// Latency: o_tick is combinational from the count; the counter restarts on the tick edge.
// Backpressure: none; disabling holds the count at 0.
module fnd_tick_prescaler (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_en,
  input  logic [31:0] i_div,
  output logic        o_tick
);
  logic [31:0] cnt;
  logic [31:0] last;

  // A divider of 0 behaves like 1 so the tick fires every cycle
  assign last   = (i_div == 32'd0) ? 32'd0 : i_div - 32'd1;
  // >= keeps the counter from running away if the divider shrinks mid-count
  assign o_tick = i_en && (cnt >= last);

  // Free-running count that wraps at the terminal value, parked at 0 when idle
  always_ff @(posedge i_clk) begin
    if (!i_reset || !i_en) begin
      cnt <= '0;
    end else if (cnt >= last) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 32'd1;
    end
  end
endmodule

// File: rtl/fnd_axi_lite_regs.sv
// AXI4-Lite register file (CTRL, VALUE, VERSION, TICK_DIV) driving the FND controller inputs.
// Latency: registers update on the edge completing AW+W, B one cycle later; R data one cycle after AR.
// Backpressure: one write and one read outstanding; AW/W/AR refused until B/R is accepted.
// Optional auto-count (prescaler + TICK_DIV register) enabled by defining FND_AUTO_COUNT_EN.
module fnd_axi_lite_regs #(
  parameter int          C_ADDR_WIDTH = 4,
  parameter int          C_DATA_WIDTH = 32,
  parameter int unsigned VALUE_MAX    = fnd_regs_pkg::VALUE_MAX,
  parameter logic [31:0] TICK_DIV_RST = 32'd100_000_000,
  parameter logic [31:0] VERSION      = 32'h464E_4401
) (
  input  logic                i_clk,
  input  logic                i_reset,
  fnd_axi_lite_regs_if.slave  s_axi,
  output logic [13:0]         o_value,
  output logic                o_OnOffSW,
  output logic                o_ClearBTN
);
  import fnd_regs_pkg::*;

  localparam logic [13:0] VMAX14 = 14'(VALUE_MAX);

  logic [C_ADDR_WIDTH-1:0] aw_addr;
  logic [C_ADDR_WIDTH-1:0] ar_addr;
  assign aw_addr = s_axi.awaddr;
  assign ar_addr = s_axi.araddr;

  // Write channel state
  wr_state_e   w_state;
  logic        aw_rdy;
  logic        w_rdy;
  logic        b_vld;
  logic [1:0]  aw_idx;
  logic [31:0] w_dat;
  logic [3:0]  w_strb;

  // Read channel state
  rd_state_e               r_state;
  logic                    ar_rdy;
  logic                    r_vld;
  logic [C_DATA_WIDTH-1:0] r_dat;

  // Register storage
  logic        ctrl_on;
  logic        ctrl_clear;
  logic        ctrl_auto;
  logic [13:0] value_q;

  // Write event seen by the register file this cycle
  logic        wr_fire;
  logic [3:0]  wr_off;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic [31:0] merged;
  logic [13:0] value_sat;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{aw_addr[1:0], ar_addr[1:0]};

`ifdef FND_AUTO_COUNT_EN
  logic [31:0] tick_div;
  logic        tick;

  fnd_tick_prescaler u_prescaler (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (ctrl_auto && !ctrl_clear),
    .i_div   (tick_div),
    .o_tick  (tick)
  );
`else
  logic unused_tick_div_rst;
  assign ctrl_auto           = 1'b0;
  assign unused_tick_div_rst = ^TICK_DIV_RST;
`endif

  // Software-visible word of the register at a given offset
  function automatic logic [31:0] read_reg(input logic [3:0] off);
    logic [31:0] r;
    r = '0;
    case (off)
      OFF_CTRL: begin
        r[CTRL_ON]    = ctrl_on;
        r[CTRL_CLEAR] = ctrl_clear;
        r[CTRL_AUTO]  = ctrl_auto;
      end
      OFF_VALUE:    r[13:0] = value_q;
      OFF_VERSION:  r = VERSION;
`ifdef FND_AUTO_COUNT_EN
      OFF_TICK_DIV: r = tick_div;
`endif
      default:      r = '0;
    endcase
    return r;
  endfunction

  // Select address/data for the write that completes this cycle (fresh or latched side)
  always_comb begin
    wr_fire = 1'b0;
    wr_off  = {aw_addr[3:2], 2'b00};
    wr_data = s_axi.wdata;
    wr_be   = s_axi.wstrb;
    case (w_state)
      W_IDLE:   wr_fire = s_axi.awvalid && s_axi.wvalid;
      W_HAVE_A: begin
        wr_fire = s_axi.wvalid;
        wr_off  = {aw_idx, 2'b00};
      end
      W_HAVE_D: begin
        wr_fire = s_axi.awvalid;
        wr_data = w_dat;
        wr_be   = w_strb;
      end
      default:  wr_fire = 1'b0;
    endcase
  end

  // Merge strobes into the current word, then clamp for VALUE
  always_comb begin
    merged    = apply_strb(read_reg(wr_off), wr_data, wr_be);
    value_sat = (merged > 32'(VALUE_MAX)) ? VMAX14 : merged[13:0];
  end

  // Write FSM: pair AW and W in any order, then hold B until accepted
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      w_state <= W_IDLE;
      aw_rdy  <= 1'b1;
      w_rdy   <= 1'b1;
      b_vld   <= 1'b0;
      aw_idx  <= '0;
      w_dat   <= '0;
      w_strb  <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (s_axi.awvalid && s_axi.wvalid) begin
            aw_rdy  <= 1'b0;
            w_rdy   <= 1'b0;
            b_vld   <= 1'b1;
            w_state <= W_RESP;
          end else if (s_axi.awvalid) begin
            aw_idx  <= aw_addr[3:2];
            aw_rdy  <= 1'b0;
            w_state <= W_HAVE_A;
          end else if (s_axi.wvalid) begin
            w_dat   <= s_axi.wdata;
            w_strb  <= s_axi.wstrb;
            w_rdy   <= 1'b0;
            w_state <= W_HAVE_D;
          end
        end
        W_HAVE_A: begin
          if (s_axi.wvalid) begin
            w_rdy   <= 1'b0;
            b_vld   <= 1'b1;
            w_state <= W_RESP;
          end
        end
        W_HAVE_D: begin
          if (s_axi.awvalid) begin
            aw_rdy  <= 1'b0;
            b_vld   <= 1'b1;
            w_state <= W_RESP;
          end
        end
        W_RESP: begin
          if (s_axi.bready) begin
            b_vld   <= 1'b0;
            aw_rdy  <= 1'b1;
            w_rdy   <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: begin
          aw_rdy  <= 1'b1;
          w_rdy   <= 1'b1;
          b_vld   <= 1'b0;
          w_state <= W_IDLE;
        end
      endcase
    end
  end

  // Register file: software writes override an auto-count tick in the same cycle
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      ctrl_on    <= 1'b0;
      ctrl_clear <= 1'b0;
      value_q    <= '0;
`ifdef FND_AUTO_COUNT_EN
      ctrl_auto  <= 1'b0;
      tick_div   <= TICK_DIV_RST;
`endif
    end else begin
`ifdef FND_AUTO_COUNT_EN
      if (tick) begin
        value_q <= (value_q == VMAX14) ? 14'd0 : value_q + 14'd1;
      end
`endif
      if (wr_fire) begin
        case (wr_off)
          OFF_CTRL: begin
            ctrl_on    <= merged[CTRL_ON];
            ctrl_clear <= merged[CTRL_CLEAR];
`ifdef FND_AUTO_COUNT_EN
            ctrl_auto  <= merged[CTRL_AUTO];
`endif
          end
          OFF_VALUE:    value_q  <= value_sat;
`ifdef FND_AUTO_COUNT_EN
          OFF_TICK_DIV: tick_div <= merged;
`endif
          default:      ;
        endcase
      end
    end
  end

  // Read FSM: capture the word on AR, hold R until accepted
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= R_IDLE;
      ar_rdy  <= 1'b1;
      r_vld   <= 1'b0;
      r_dat   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (s_axi.arvalid) begin
            r_dat   <= C_DATA_WIDTH'(read_reg({ar_addr[3:2], 2'b00}));
            r_vld   <= 1'b1;
            ar_rdy  <= 1'b0;
            r_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (s_axi.rready) begin
            r_vld   <= 1'b0;
            ar_rdy  <= 1'b1;
            r_state <= R_IDLE;
          end
        end
        default: begin
          r_vld   <= 1'b0;
          ar_rdy  <= 1'b1;
          r_state <= R_IDLE;
        end
      endcase
    end
  end

  assign s_axi.awready = aw_rdy;
  assign s_axi.wready  = w_rdy;
  assign s_axi.bvalid  = b_vld;
  assign s_axi.bresp   = 2'b00;
  assign s_axi.arready = ar_rdy;
  assign s_axi.rvalid  = r_vld;
  assign s_axi.rdata   = r_dat;
  assign s_axi.rresp   = 2'b00;

  assign o_value    = value_q;
  assign o_OnOffSW  = ctrl_on;
  assign o_ClearBTN = ctrl_clear;
endmodule

// File: tb/tb_fnd_axi_lite_regs.sv
// Bench for fnd_axi_lite_regs: directed cases plus randomized traffic against a register-map model.
// Checks handshake timing, strobes, saturation, backpressure, reset abort and (with FND_AUTO_COUNT_EN) auto-count.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_fnd_axi_lite_regs;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fnd_axi_lite_regs_if #(.C_ADDR_WIDTH(4)) axi ();

  logic [13:0] value;
  logic        on_sw;
  logic        clr_btn;

  fnd_axi_lite_regs dut (
    .i_clk      (clk),
    .i_reset    (rst_n),
    .s_axi      (axi),
    .o_value    (value),
    .o_OnOffSW  (on_sw),
    .o_ClearBTN (clr_btn)
  );

`ifdef FND_AUTO_COUNT_EN
  localparam bit AUTO_EN = 1'b1;
`else
  localparam bit AUTO_EN = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int b_beats = 0;

  // Reference register contents
  logic [2:0]  m_ctrl;
  int unsigned m_value;
  logic [31:0] m_tick;

  always @(posedge clk) if (rst_n && axi.bvalid && axi.bready) b_beats++;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_ctrl  = 3'b000;
    m_value = 0;
    m_tick  = AUTO_EN ? 32'd100_000_000 : 32'd0;
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] a);
    case (a)
      4'h0:    return {29'd0, m_ctrl};
      4'h4:    return m_value;
      4'h8:    return 32'h464E_4401;
      default: return AUTO_EN ? m_tick : 32'd0;
    endcase
  endfunction

  function automatic void model_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] mask;
    logic [31:0] word;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    word = (model_read(a) & ~mask) | (d & mask);
    case (a)
      4'h0:    m_ctrl  = AUTO_EN ? word[2:0] : {1'b0, word[1:0]};
      4'h4:    m_value = (word > 32'd9999) ? 9999 : word;
      4'hC:    if (AUTO_EN) m_tick = word;
      default: ;
    endcase
  endfunction

  task automatic check_outputs(input string tag);
    check_val({tag, "_value"}, value, m_value);
    check_val({tag, "_on"}, on_sw, m_ctrl[0]);
    check_val({tag, "_clear"}, clr_btn, m_ctrl[1]);
  endtask

  // One write with independent AW/W start delays and a B-ready delay
  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_dly,
                           output logic [13:0] v_after);
    bit aw_done = 1'b0;
    bit w_done  = 1'b0;
    bit hs_aw;
    bit hs_w;
    int cyc = 0;
    while (!(aw_done && w_done) && cyc < 50) begin
      @(negedge clk);
      axi.awaddr  = a;
      axi.wdata   = d;
      axi.wstrb   = s;
      axi.awvalid = !aw_done && (cyc >= aw_dly);
      axi.wvalid  = !w_done && (cyc >= w_dly);
      hs_aw = axi.awvalid && axi.awready;
      hs_w  = axi.wvalid && axi.wready;
      @(posedge clk);
      aw_done = aw_done | hs_aw;
      w_done  = w_done | hs_w;
      cyc++;
    end
    if (aw_done && w_done) model_write(a, d, s);
    @(negedge clk);
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    v_after = value;
    check_val("wr_handshake", {aw_done, w_done}, 2'b11);
    check_val("b_next_cycle", axi.bvalid, 1'b1);
    check_val("bresp", axi.bresp, 2'b00);
    for (int i = 0; i < b_dly; i++) begin
      @(negedge clk);
      check_val("b_hold", axi.bvalid, 1'b1);
      check_val("aw_blocked", axi.awready, 1'b0);
    end
    axi.bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    axi.bready = 1'b0;
    check_val("b_done", axi.bvalid, 1'b0);
  endtask

  // One read; exp is the model's word at the AR handshake
  task automatic axi_read(input logic [3:0] a, input int r_dly, input logic [31:0] exp, input string tag);
    bit hs = 1'b0;
    int cyc = 0;
    while (!hs && cyc < 50) begin
      @(negedge clk);
      axi.araddr  = a;
      axi.arvalid = 1'b1;
      hs = axi.arready;
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    axi.arvalid = 1'b0;
    check_val({tag, "_ar_hs"}, hs, 1'b1);
    check_val({tag, "_rvalid"}, axi.rvalid, 1'b1);
    check_val({tag, "_rdata"}, axi.rdata, exp);
    check_val({tag, "_rresp"}, axi.rresp, 2'b00);
    for (int i = 0; i < r_dly; i++) begin
      @(negedge clk);
      check_val({tag, "_r_hold"}, {axi.rvalid, axi.rdata}, {1'b1, exp});
    end
    axi.rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    axi.rready = 1'b0;
    check_val({tag, "_r_done"}, axi.rvalid, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [13:0] v;
    logic [31:0] exp;
    logic [3:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    int          b0;
    int          t;

    rst_n = 1'b0;
    axi.awaddr = '0; axi.awvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0;
    axi.bready = 1'b0; axi.araddr = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
    model_reset();

    // Reset held for 3 cycles
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs("reset");
    check_val("reset_ready", {axi.awready, axi.wready, axi.arready}, 3'b111);
    check_val("reset_valid", {axi.bvalid, axi.rvalid}, 2'b00);
    check_val("reset_rdata", axi.rdata, 32'd0);

    // AW and W together
    axi_write(4'h4, 32'd1234, 4'hF, 0, 0, 0, v);
    check_outputs("value_1234");
    axi_read(4'h4, 0, 32'd1234, "rd_1234");

    // AW three cycles ahead of W; ON must not appear early, one B beat only
    b0 = b_beats;
    fork
      axi_write(4'h0, 32'h1, 4'hF, 0, 3, 0, v);
      begin
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check_val("on_before_w", on_sw, 1'b0);
        end
      end
    join
    check_outputs("ctrl_on");
    repeat (3) @(negedge clk);
    check_val("one_b_beat", b_beats - b0, 1);

    // W ahead of AW
    axi_write(4'h4, 32'd77, 4'hF, 2, 0, 1, v);
    check_outputs("w_first");

    // Saturation then byte strobes
    axi_write(4'h4, 32'h0000_FFFF, 4'hF, 0, 0, 0, v);
    check_outputs("saturate");
    axi_write(4'h4, 32'h0000_0012, 4'h1, 0, 0, 0, v);
    check_outputs("strb_sat");
    axi_write(4'h4, 32'h0, 4'hF, 0, 0, 0, v);
    axi_write(4'h4, 32'h0000_AB12, 4'h1, 0, 0, 0, v);
    check_outputs("strb_low");
    axi_read(4'h4, 0, model_read(4'h4), "rd_strb");

    // VERSION read-only, CTRL unused bits, TICK_DIV presence
    axi_write(4'h8, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, v);
    axi_read(4'h8, 1, 32'h464E_4401, "rd_version");
    axi_write(4'h0, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, v);
    check_outputs("ctrl_all");
    axi_read(4'h0, 0, model_read(4'h0), "rd_ctrl");
    axi_write(4'h0, 32'h0, 4'hF, 0, 0, 0, v);
    axi_write(4'hC, 32'h0000_1234, 4'hF, 0, 0, 0, v);
    axi_read(4'hC, 0, model_read(4'hC), "rd_tickdiv");

    // Read in the same cycle as a write to the same register returns the old value
    exp = model_read(4'h4);
    fork
      axi_write(4'h4, 32'd4321, 4'hF, 0, 0, 0, v);
      axi_read(4'h4, 0, exp, "rd_old");
    join
    axi_read(4'h4, 0, 32'd4321, "rd_new");

    // Backpressure on both B and R while new AW/AR are offered
    exp = model_read(4'h4);
    @(negedge clk);
    axi.awaddr = 4'h4; axi.wdata = 32'd555; axi.wstrb = 4'hF;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1;
    axi.araddr = 4'h4; axi.arvalid = 1'b1;
    @(posedge clk);
    model_write(4'h4, 32'd555, 4'hF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      axi.awaddr = 4'h0; axi.araddr = 4'h8;
      axi.awvalid = 1'b1; axi.wvalid = 1'b0; axi.arvalid = 1'b1;
      check_val("bp_aw_blocked", axi.awready, 1'b0);
      check_val("bp_ar_blocked", axi.arready, 1'b0);
      check_val("bp_bvalid", axi.bvalid, 1'b1);
      check_val("bp_rvalid", axi.rvalid, 1'b1);
      check_val("bp_rdata", axi.rdata, exp);
    end
    @(negedge clk);
    axi.awvalid = 1'b0; axi.arvalid = 1'b0;
    axi.bready = 1'b1; axi.rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    axi.bready = 1'b0; axi.rready = 1'b0;
    check_val("bp_released", {axi.bvalid, axi.rvalid}, 2'b00);
    check_outputs("bp_value");

`ifdef FND_AUTO_COUNT_EN
    // Auto-count with a 2-cycle tick, wrap at the limit
    axi_write(4'hC, 32'd2, 4'hF, 0, 0, 0, v);
    axi_write(4'h4, 32'd9998, 4'hF, 0, 0, 0, v);
    axi_write(4'h0, 32'h5, 4'hF, 0, 0, 0, v);
    check_val("auto_pre", value, 32'd9998);
    t = 0;
    while (value != 14'd9999 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check_val("auto_9999", value, 32'd9999);
    @(negedge clk);
    check_val("auto_hold", value, 32'd9999);
    @(negedge clk);
    check_val("auto_wrap", value, 32'd0);
    // Tick every cycle; a software write lands on a tick edge and must win
    axi_write(4'hC, 32'd0, 4'hF, 0, 0, 0, v);
    axi_write(4'h4, 32'd5, 4'hF, 0, 0, 0, v);
    check_val("auto_write_wins", v, 32'd5);
    axi_write(4'h0, 32'h1, 4'hF, 0, 0, 0, v);
    axi_write(4'h4, 32'd0, 4'hF, 0, 0, 0, v);
    check_outputs("auto_stopped");
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 30; n++) begin
      a = {2'($urandom_range(0, 3)), 2'b00};
      d = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 12000) : $urandom;
      s = 4'($urandom_range(0, 15));
      if (AUTO_EN && a == 4'h0) begin
        d[2] = 1'b0;
        s[0] = 1'b1;
      end
      axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), v);
      check_outputs("rnd_wr");
      a = {2'($urandom_range(0, 3)), 2'b00};
      axi_read(a, $urandom_range(0, 2), model_read(a), "rnd_rd");
    end

    // Reset in the middle of a write (AW only) and a read
    @(negedge clk);
    axi.awaddr = 4'h4; axi.awvalid = 1'b1;
    axi.araddr = 4'h4; axi.arvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    axi.awvalid = 1'b0; axi.arvalid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    axi.bready = 1'b1; axi.rready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("abort_no_beat", {axi.bvalid, axi.rvalid}, 2'b00);
    end
    axi.bready = 1'b0; axi.rready = 1'b0;
    check_val("abort_ready", {axi.awready, axi.wready, axi.arready}, 3'b111);
    check_outputs("abort_regs");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
